// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered 8-bit UART transmitter. Bytes written by the SFR block are queued in
// a small FIFO and serialised LSB-first on uart_tx at a fixed bit period. A
// frame is start(0), 8 data bits, optional even parity bit, and stop(1).
// Back-to-back frames are emitted with no idle gap while the FIFO holds data.
//
// Optional feature macro:
//   UART_TX_PARITY_EN  defined   -> 8E1 frames (even parity bit before stop)
//                      undefined -> 8N1 frames (no parity state or logic)
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit, >= 2
//   DEPTH         FIFO entries, power of two, >= 2
//
// Ports:
//   clk       in   system clock
//   nrst      in   asynchronous active-low reset
//   wr_valid  in   push strobe, one push per cycle while high
//   wr_data   in   byte to push
//   ovf_clr   in   clears the sticky overflow flag
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
//   level     out  current FIFO occupancy
//   ovf       out  sticky: a push was dropped because the FIFO was full
//   busy      out  a frame is on the line
//   uart_tx   out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    input  logic                     ovf_clr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     busy,
    output logic                     uart_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity over one data byte: the parity bit makes the total count of
    // ones (data plus parity) even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [AW:0]   level_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          ovf_r;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic [7:0]    head_s;

    // -------------------------------------------------------------------------
    // Transmitter state
    // -------------------------------------------------------------------------
    state_t        state_r;
    state_t        state_nxt_s;
    logic [BW-1:0] baud_cnt_r;
    logic [BW-1:0] baud_nxt_s;
    logic [2:0]    bit_cnt_r;
    logic [2:0]    bit_cnt_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic          bit_end_s;
    logic          tx_r;
    logic          tx_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
`ifdef UART_TX_PARITY_EN
    logic          parity_r;
    logic          parity_nxt_s;
`endif

    assign head_s    = mem_r[rd_ptr_r];
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    // Push/drop qualification and next occupancy. Rejection uses the
    // registered (pre-edge) full flag even when a pop happens on the same edge.
    always_comb begin
        push_s      = wr_valid & ~full_r;
        drop_s      = wr_valid & full_r;
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + 1'b1;
            2'b01:   level_nxt_s = level_r - 1'b1;
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO data array; contents are don't-care until written, pointers
    // define validity, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, registered status flags and sticky overflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LEVEL_FULL);
            empty_r <= (level_nxt_s == '0);
            // A drop on the same edge as a clear keeps the flag set.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: each non-idle state lasts CLKS_PER_BIT cycles per
    // bit; STOP chains straight into START when more data is queued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    state_nxt_s = ST_STOP;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s && !empty_r) begin
                    state_nxt_s = ST_START;
                end else if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: pop request, counters, shifter and the next value of
    // the registered line/busy outputs. The line value is derived from the
    // next state so that uart_tx changes on the same edge as the state.
    always_comb begin
        pop_s         = 1'b0;
        baud_nxt_s    = '0;
        bit_cnt_nxt_s = 3'd0;
        shift_nxt_s   = shift_r;
        tx_nxt_s      = 1'b1;
        busy_nxt_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s  = parity_r;
`endif

        if ((state_r == ST_IDLE) && !empty_r) begin
            pop_s = 1'b1;
        end else if ((state_r == ST_STOP) && bit_end_s && !empty_r) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // Baud counter runs 0..CLKS_PER_BIT-1 in every non-idle state.
        if ((state_r == ST_IDLE) || bit_end_s) begin
            baud_nxt_s = '0;
        end else begin
            baud_nxt_s = baud_cnt_r + 1'b1;
        end

        // Bit counter only advances across DATA bit boundaries; the 3-bit
        // wrap from 7 to 0 coincides with leaving DATA.
        if ((state_r == ST_DATA) && bit_end_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 1'b1;
        end else if (state_r == ST_DATA) begin
            bit_cnt_nxt_s = bit_cnt_r;
        end else begin
            bit_cnt_nxt_s = 3'd0;
        end

        // Shifter: load the FIFO head on pop, shift right after each data bit
        // so bit 0 always holds the bit currently on the line.
        if (pop_s) begin
            shift_nxt_s = head_s;
`ifdef UART_TX_PARITY_EN
            parity_nxt_s = even_parity(head_s);
`endif
        end else if ((state_r == ST_DATA) && bit_end_s) begin
            shift_nxt_s = {1'b0, shift_r[7:1]};
        end else begin
            shift_nxt_s = shift_r;
        end

        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = 1'b1;
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt_s = parity_nxt_s;
`endif
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase

        if (state_nxt_s != ST_IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // Transmitter datapath and registered line/busy outputs; reset drives the
    // line high immediately, abandoning any partial frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            baud_cnt_r <= baud_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= busy_nxt_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_nxt_s;
`endif
        end
    end

    assign full    = full_r;
    assign empty   = empty_r;
    assign level   = level_r;
    assign ovf     = ovf_r;
    assign busy    = busy_r;
    assign uart_tx = tx_r;

endmodule
